// File: rtl/amba3_apb_cmd_master_if.sv
// Bundle of the command, response and APB3 signals around the APB command master.
// The master modport is the requester's view; the slave modport is the view of
// whatever sits around it: the command issuer, the response consumer and the APB completer.
interface amba3_apb_cmd_master_if #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32
);
    // Command stream from the issuer
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic [DATA_BITS-1:0] cmd_wdata;

    // Response stream back to the issuer
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_write;
    logic [DATA_BITS-1:0] rsp_rdata;
    logic                 rsp_slverr;

    // APB3 bus towards the completer
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [ADDR_BITS-1:0] paddr;
    logic [DATA_BITS-1:0] pwdata;
    logic [DATA_BITS-1:0] prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_rdata, rsp_slverr,
        input  rsp_ready,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_slverr,
        output rsp_ready,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/amba3_apb_cmd_master.sv
// APB3 requester: a small command FIFO feeds a SETUP/ACCESS state machine that
// runs one APB transfer per command and parks each result in a single-entry
// response register. Responses leave in command order, one per command.
module amba3_apb_cmd_master #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int CMD_DEPTH = 4
) (
    input  logic                          pclk,
    input  logic                          preset_n,
    amba3_apb_cmd_master_if.master        bus,
    output logic                          busy_o
);

    localparam int PTR_BITS = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam logic [CNT_BITS-1:0] FULL_COUNT = CNT_BITS'(CMD_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Command FIFO storage and bookkeeping
    logic                 fifoWrite_q [CMD_DEPTH];
    logic [ADDR_BITS-1:0] fifoAddr_q  [CMD_DEPTH];
    logic [DATA_BITS-1:0] fifoWdata_q [CMD_DEPTH];
    logic [PTR_BITS-1:0]  wrPtr_q;
    logic [PTR_BITS-1:0]  rdPtr_q;
    logic [CNT_BITS-1:0]  count_q;
    logic [CNT_BITS-1:0]  count_d;
    logic                 cmdReady_q;
    logic                 push;
    logic                 pop;

    // Transfer state, registered APB outputs and the response slot
    state_t               state_q;
    logic                 psel_q;
    logic                 penable_q;
    logic                 pwrite_q;
    logic [ADDR_BITS-1:0] paddr_q;
    logic [DATA_BITS-1:0] pwdata_q;
    logic                 rspValid_q;
    logic                 rspWrite_q;
    logic [DATA_BITS-1:0] rspRdata_q;
    logic                 rspSlverr_q;
    logic                 fifoNonEmpty;
    logic                 rspSlotFree;

    // A command is taken only against the registered ready, so a full FIFO
    // refuses a push even in the cycle its head is being popped.
    assign push         = bus.cmd_valid && cmdReady_q;
    assign pop          = (state_q == ACCESS) && bus.pready;
    assign fifoNonEmpty = (count_q != '0);
    assign rspSlotFree  = !rspValid_q || bus.rsp_ready;

    // Next occupancy: a simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_BITS'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_BITS'(1);
        end
    end

    // FIFO payload storage; contents are only meaningful between the pointers
    always_ff @(posedge pclk) begin
        if (push) begin
            fifoWrite_q[wrPtr_q] <= bus.cmd_write;
            fifoAddr_q[wrPtr_q]  <= bus.cmd_addr;
            fifoWdata_q[wrPtr_q] <= bus.cmd_wdata;
        end
    end

    // FIFO pointers, occupancy and the registered ready flag
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            cmdReady_q <= 1'b0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_BITS'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_BITS'(1);
            end
            count_q    <= count_d;
            cmdReady_q <= (count_d != FULL_COUNT);
        end
    end

    // Transfer sequencer: IDLE -> SETUP -> ACCESS (wait states) -> IDLE, with
    // the response captured on the completing ACCESS edge
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rspValid_q  <= 1'b0;
            rspWrite_q  <= 1'b0;
            rspRdata_q  <= '0;
            rspSlverr_q <= 1'b0;
        end else begin
            if (rspValid_q && bus.rsp_ready) begin
                rspValid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (fifoNonEmpty && rspSlotFree) begin
                        state_q   <= SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        pwrite_q  <= fifoWrite_q[rdPtr_q];
                        paddr_q   <= fifoAddr_q[rdPtr_q];
                        pwdata_q  <= fifoWdata_q[rdPtr_q];
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (bus.pready) begin
                        state_q     <= IDLE;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rspValid_q  <= 1'b1;
                        rspWrite_q  <= pwrite_q;
                        rspRdata_q  <= pwrite_q ? '0 : bus.prdata;
                        rspSlverr_q <= bus.pslverr;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmdReady_q;
    assign bus.psel       = psel_q;
    assign bus.penable    = penable_q;
    assign bus.pwrite     = pwrite_q;
    assign bus.paddr      = paddr_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.rsp_valid  = rspValid_q;
    assign bus.rsp_write  = rspWrite_q;
    assign bus.rsp_rdata  = rspRdata_q;
    assign bus.rsp_slverr = rspSlverr_q;

    assign busy_o = fifoNonEmpty || (state_q != IDLE) || rspValid_q;

endmodule

// File: tb/tb_amba3_apb_cmd_master.sv
// Bench for the APB command master: an APB memory completer with programmable
// wait states and an error address, a response consumer with selectable
// backpressure, and a scoreboard that predicts every response from the
// command sequence and a reference memory.
module tb_amba3_apb_cmd_master;

    localparam int ADDR_BITS = 32;
    localparam int DATA_BITS = 32;
    localparam int CMD_DEPTH = 4;
    localparam logic [31:0] ERR_ADDR = 32'h0000_0018;
    localparam int N_RAND = 1000;

    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic        slverr;
    } exp_t;

    logic pclk;
    logic preset_n;
    logic busy;

    amba3_apb_cmd_master_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) bus ();

    amba3_apb_cmd_master #(
        .ADDR_BITS(ADDR_BITS),
        .DATA_BITS(DATA_BITS),
        .CMD_DEPTH(CMD_DEPTH)
    ) dut (
        .pclk    (pclk),
        .preset_n(preset_n),
        .bus     (bus),
        .busy_o  (busy)
    );

    int total = 0;
    int bad = 0;
    int cycleCnt = 0;
    int waitMode = 0;
    int rspPolicy = 1;
    int lastAccessLen = 0;
    logic [31:0] lastRdata = '0;
    exp_t expQ[$];
    int rspCycles[$];
    logic [31:0] refMem [logic [31:0]];
    logic [31:0] slaveMem [logic [31:0]];
    logic [31:0] wrAddr [N_RAND];

    // Free-running clock and a cycle counter used for response spacing
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        forever begin
            @(posedge pclk);
            cycleCnt++;
        end
    end

    // Safety net so the run can never hang
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Contents an unwritten completer location returns
    function automatic logic [31:0] defaultData(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Offer one command from a falling edge; record its predicted response once accepted
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d);
        int guard;
        exp_t e;
        guard = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        while (!bus.cmd_ready && guard < 5000) begin
            @(negedge pclk);
            guard++;
        end
        if (!bus.cmd_ready) begin
            checkOutput("cmdAcceptTimeout", 64'd0, 64'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        e.write  = w;
        e.rdata  = w ? 32'h0 : (refMem.exists(a) ? refMem[a] : defaultData(a));
        e.slverr = (a == ERR_ADDR);
        expQ.push_back(e);
        if (w) refMem[a] = d;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
    endtask

    // Wait for the master to go quiet with every predicted response consumed
    task automatic waitIdle(input int bound);
        int n;
        n = 0;
        while ((busy || expQ.size() != 0) && n < bound) begin
            @(negedge pclk);
            n++;
        end
        if (busy || expQ.size() != 0) checkOutput("idleTimeout", 64'd0, 64'd1);
    endtask

    // APB memory completer plus bus protocol checks, evaluated on falling edges
    initial begin
        int waitLeft;
        int accessLen;
        logic prevPsel, prevPenable, prevPwrite;
        logic [31:0] prevPaddr, prevPwdata;
        waitLeft = 0;
        accessLen = 0;
        prevPsel = 1'b0;
        prevPenable = 1'b0;
        prevPwrite = 1'b0;
        prevPaddr = '0;
        prevPwdata = '0;
        bus.pready  = 1'b0;
        bus.prdata  = '0;
        bus.pslverr = 1'b0;
        forever begin
            @(negedge pclk);
            if (bus.penable) begin
                checkOutput("penableWithoutPsel", {63'd0, bus.psel}, 64'd1);
                if (!prevPenable) begin
                    checkOutput("accessAfterSetup", {62'd0, prevPsel, prevPenable}, 64'd2);
                end
                checkOutput("paddrStable", {32'd0, bus.paddr}, {32'd0, prevPaddr});
                checkOutput("pwdataStable", {32'd0, bus.pwdata}, {32'd0, prevPwdata});
                checkOutput("pwriteStable", {63'd0, bus.pwrite}, {63'd0, prevPwrite});
            end
            if (bus.psel && !bus.penable) begin
                waitLeft  = (waitMode < 0) ? int'($urandom_range(0, 10)) : waitMode;
                accessLen = 0;
            end
            if (preset_n && bus.psel && bus.penable) begin
                accessLen++;
                if (waitLeft == 0) begin
                    bus.pready = 1'b1;
                    bus.pslverr = (bus.paddr == ERR_ADDR);
                    if (bus.pwrite) begin
                        slaveMem[bus.paddr] = bus.pwdata;
                        bus.prdata = $urandom;
                    end else begin
                        bus.prdata = slaveMem.exists(bus.paddr) ? slaveMem[bus.paddr] : defaultData(bus.paddr);
                    end
                    lastAccessLen = accessLen;
                end else begin
                    bus.pready  = 1'b0;
                    bus.prdata  = $urandom;
                    bus.pslverr = 1'($urandom_range(0, 1));
                    waitLeft--;
                end
            end else begin
                bus.pready  = 1'($urandom_range(0, 1));
                bus.prdata  = $urandom;
                bus.pslverr = 1'($urandom_range(0, 1));
            end
            prevPsel    = bus.psel;
            prevPenable = bus.penable;
            prevPwrite  = bus.pwrite;
            prevPaddr   = bus.paddr;
            prevPwdata  = bus.pwdata;
        end
    end

    // Response consumer: drives rsp_ready and scores each handshake in order
    initial begin
        exp_t e;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge pclk);
            case (rspPolicy)
                0:       bus.rsp_ready = 1'b0;
                1:       bus.rsp_ready = 1'b1;
                default: bus.rsp_ready = 1'($urandom_range(0, 1));
            endcase
            if (preset_n && bus.rsp_valid && bus.rsp_ready) begin
                rspCycles.push_back(cycleCnt);
                lastRdata = bus.rsp_rdata;
                if (expQ.size() == 0) begin
                    checkOutput("rspUnexpected", 64'd1, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rspWrite", {63'd0, bus.rsp_write}, {63'd0, e.write});
                    checkOutput("rspRdata", {32'd0, bus.rsp_rdata}, {32'd0, e.rdata});
                    checkOutput("rspSlverr", {63'd0, bus.rsp_slverr}, {63'd0, e.slverr});
                end
            end
        end
    end

    // Directed scenarios followed by the randomized write/read sweep
    initial begin
        int guard;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        preset_n = 1'b0;

        // Reset values while held in reset
        repeat (3) @(negedge pclk);
        checkOutput("rstCmdReady", {63'd0, bus.cmd_ready}, 64'd0);
        checkOutput("rstPsel", {63'd0, bus.psel}, 64'd0);
        checkOutput("rstPenable", {63'd0, bus.penable}, 64'd0);
        checkOutput("rstPwrite", {63'd0, bus.pwrite}, 64'd0);
        checkOutput("rstPaddr", {32'd0, bus.paddr}, 64'd0);
        checkOutput("rstPwdata", {32'd0, bus.pwdata}, 64'd0);
        checkOutput("rstRspValid", {63'd0, bus.rsp_valid}, 64'd0);
        checkOutput("rstRspFields", {30'd0, bus.rsp_write, bus.rsp_slverr, bus.rsp_rdata}, 64'd0);
        checkOutput("rstBusy", {63'd0, busy}, 64'd0);
        preset_n = 1'b1;
        repeat (2) @(negedge pclk);
        checkOutput("relCmdReady", {63'd0, bus.cmd_ready}, 64'd1);
        checkOutput("relBusy", {63'd0, busy}, 64'd0);

        // Single zero-wait write: SETUP, ACCESS, response on successive edges
        $display("[TB] single write");
        waitMode = 0;
        rspPolicy = 1;
        applyStimulus(1'b1, 32'h0000_0800, 32'h0004_0000);
        checkOutput("t1IdleAfterAccept", {63'd0, bus.psel}, 64'd0);
        @(negedge pclk);
        checkOutput("t1SetupSel", {62'd0, bus.psel, bus.penable}, 64'd2);
        checkOutput("t1SetupAddr", {32'd0, bus.paddr}, 64'h800);
        checkOutput("t1SetupWdata", {32'd0, bus.pwdata}, 64'h0004_0000);
        checkOutput("t1SetupWrite", {63'd0, bus.pwrite}, 64'd1);
        @(negedge pclk);
        checkOutput("t1AccessSel", {62'd0, bus.psel, bus.penable}, 64'd3);
        @(negedge pclk);
        checkOutput("t1RspValid", {63'd0, bus.rsp_valid}, 64'd1);
        checkOutput("t1BusReleased", {62'd0, bus.psel, bus.penable}, 64'd0);
        checkOutput("t1RspWrite", {63'd0, bus.rsp_write}, 64'd1);
        checkOutput("t1RspRdata", {32'd0, bus.rsp_rdata}, 64'd0);
        checkOutput("t1RspSlverr", {63'd0, bus.rsp_slverr}, 64'd0);
        waitIdle(100);
        checkOutput("t1AccessLen", 64'(lastAccessLen), 64'd1);

        // Write then read back through three wait states
        $display("[TB] wait-state write/read");
        waitMode = 3;
        applyStimulus(1'b1, 32'h0000_0040, 32'h8000_3333);
        applyStimulus(1'b0, 32'h0000_0040, 32'h0);
        waitIdle(200);
        checkOutput("t2AccessLen", 64'(lastAccessLen), 64'd4);
        checkOutput("t2ReadBack", {32'd0, lastRdata}, 64'h8000_3333);

        // Fill the FIFO behind a held response, then drain with rsp_ready high
        $display("[TB] fifo fill");
        waitMode = 0;
        rspPolicy = 0;
        repeat (2) @(negedge pclk);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h0000_0200 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
        end
        checkOutput("t3FullNotReady", {63'd0, bus.cmd_ready}, 64'd0);
        checkOutput("t3RspHeld", {63'd0, bus.rsp_valid}, 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0000_0300;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            checkOutput("t3StallWhileFull", {63'd0, bus.cmd_ready}, 64'd0);
        end
        bus.cmd_valid = 1'b0;
        checkOutput("t3QueuedCount", 64'(expQ.size()), 64'd5);
        rspCycles.delete();
        rspPolicy = 1;
        waitIdle(200);
        checkOutput("t3RspCount", 64'(rspCycles.size()), 64'd5);
        for (int i = 1; i < rspCycles.size(); i++) begin
            checkOutput("t3RspSpacing", 64'(rspCycles[i] - rspCycles[i-1]), 64'd3);
        end

        // Error response on one read, clean response on the next
        $display("[TB] slave error");
        applyStimulus(1'b0, ERR_ADDR, 32'h0);
        applyStimulus(1'b0, 32'h0000_001C, 32'h0);
        waitIdle(200);

        // Reset while a transfer sits in ACCESS with two commands queued
        $display("[TB] reset mid-transfer");
        waitMode = 10;
        applyStimulus(1'b0, 32'h0000_0100, 32'h0);
        applyStimulus(1'b0, 32'h0000_0104, 32'h0);
        applyStimulus(1'b0, 32'h0000_0108, 32'h0);
        guard = 0;
        while (!bus.penable && guard < 50) begin
            @(negedge pclk);
            guard++;
        end
        checkOutput("t5InAccess", {63'd0, bus.penable}, 64'd1);
        preset_n = 1'b0;
        #1;
        checkOutput("t5RstPsel", {62'd0, bus.psel, bus.penable}, 64'd0);
        checkOutput("t5RstRspValid", {63'd0, bus.rsp_valid}, 64'd0);
        checkOutput("t5RstBusy", {63'd0, busy}, 64'd0);
        expQ.delete();
        rspCycles.delete();
        @(negedge pclk);
        preset_n = 1'b1;
        repeat (2) @(negedge pclk);
        checkOutput("t5RelCmdReady", {63'd0, bus.cmd_ready}, 64'd1);
        repeat (20) @(negedge pclk);
        checkOutput("t5NoResponses", 64'(rspCycles.size()), 64'd0);
        checkOutput("t5StillIdle", {63'd0, busy}, 64'd0);

        // Random writes over a small address pool, then reads in shuffled order
        $display("[TB] random sweep");
        waitMode = -1;
        rspPolicy = 2;
        for (int i = 0; i < N_RAND; i++) begin
            wrAddr[i] = 32'h0000_1000 + {22'd0, 8'($urandom_range(0, 63)), 2'b00};
            applyStimulus(1'b1, wrAddr[i], $urandom);
            if ($urandom_range(0, 3) == 0) @(negedge pclk);
        end
        for (int i = N_RAND - 1; i > 0; i--) begin
            int j;
            logic [31:0] t;
            j = int'($urandom_range(0, i));
            t = wrAddr[i];
            wrAddr[i] = wrAddr[j];
            wrAddr[j] = t;
        end
        for (int i = 0; i < N_RAND; i++) begin
            applyStimulus(1'b0, wrAddr[i], 32'h0);
            if ($urandom_range(0, 3) == 0) @(negedge pclk);
        end
        waitIdle(100000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
